// File: rtl/servstolic_grid.sv
// servstolic_grid: NROW x NCOL servant array with staggered reset release, per-core run
// enable and per-core rising-edge counters on q, read back through a select port.

// Stand-in servant SoC with the real core's parameters and ports. It drives q from an
// 8-bit LFSR so every core shows an irregular blink pattern once out of reset.
module servant #(
  parameter         memfile  = "",
  parameter int     memsize  = 8192,
  parameter int     sim      = 0,
  parameter int     with_csr = 1,
  parameter int     align    = 0
) (
  input  logic wb_clk,
  input  logic wb_rst,
  output logic q
);
  localparam logic [7:0] SEED = 8'(memsize + $bits(memfile) + sim + with_csr + align) | 8'h01;

  logic [7:0] lfsr_q;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      lfsr_q <= SEED;
      q      <= 1'b0;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
      q      <= lfsr_q[0];
    end
  end
endmodule

module servstolic_grid #(
  parameter int     NROW     = 4,
  parameter int     NCOL     = 4,
  parameter         MEMFILE  = "blinky.hex",
  parameter int     MEMSIZE  = 16384,
  parameter int     SIM      = 1,
  parameter int     WITH_CSR = 1,
  parameter int     ALIGN    = 0,
  parameter int     STAGGER  = 8,
  parameter int     CNT_W    = 16,
  localparam int    N        = NROW * NCOL,
  localparam int    SEL_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [N-1:0]     core_en,
  input  logic             cnt_clr,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     q,
  output logic [N-1:0]     run,
  output logic [CNT_W-1:0] cnt,
  output logic             seq_done
);
  localparam int TMR_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic {S_WAIT, S_DONE} seq_state_e;

  seq_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N-1:0]     rel_mask_q, rel_mask_d;
  logic [N-1:0]     core_rst_q;
  logic [N-1:0]     servant_q;
  logic [N-1:0]     q_q;
  logic             seq_done_q;
  logic [CNT_W-1:0] cnt_mem_q [N];
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    rel_mask_d = rel_mask_q;
    if (state_q == S_WAIT) begin
      if (timer_q == TMR_W'(STAGGER - 1)) begin
        rel_mask_d = rel_mask_q | (N'(1) << idx_q);
        timer_d    = '0;
        if (idx_q == SEL_W'(N - 1)) state_d = S_DONE;
        else                        idx_d   = idx_q + 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= S_WAIT;
      timer_q    <= '0;
      idx_q      <= '0;
      rel_mask_q <= '0;
      core_rst_q <= '1;
      seq_done_q <= 1'b0;
      q_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      rel_mask_q <= rel_mask_d;
      core_rst_q <= ~(rel_mask_q & core_en);
      seq_done_q <= (state_q == S_DONE);
      // q only tracks a core while it runs, so a held core keeps its last level
      q_q        <= (servant_q & ~core_rst_q) | (q_q & core_rst_q);
      cnt_q      <= cnt_rd;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < N; i++) cnt_mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt_clr)
          cnt_mem_q[i] <= '0;
        else if (servant_q[i] && !q_q[i] && !core_rst_q[i] && (cnt_mem_q[i] != '1))
          cnt_mem_q[i] <= cnt_mem_q[i] + 1'b1;
      end
    end
  end

  // Selects with no matching core read back zero
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) cnt_rd = cnt_mem_q[i];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_core
    servant #(
      .memfile  (MEMFILE),
      .memsize  (MEMSIZE),
      .sim      (SIM),
      .with_csr (WITH_CSR),
      .align    (ALIGN)
    ) u_servant (
      .wb_clk (wb_clk),
      .wb_rst (core_rst_q[g]),
      .q      (servant_q[g])
    );
  end

  assign q        = q_q;
  assign run      = ~core_rst_q;
  assign cnt      = cnt_q;
  assign seq_done = seq_done_q;
endmodule

// File: tb/tb_servstolic_grid.sv
// Bench for servstolic_grid: a 4x4 array, a 3x4 array and a 1x1 array with a 2-bit counter,
// checked against a timing/counting reference model driven by random selects and clears.
module tb_servstolic_grid;
  localparam int S_A = 8, N_A = 16;
  localparam int S_R = 8, N_R = 12;
  localparam int S_S = 3, N_S = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;

  logic [15:0] core_en_a = '1;
  logic [3:0]  sel_a = '0;
  logic [15:0] q_a, run_a, cnt_a;
  logic        done_a;

  logic [3:0]  sel_r = '0;
  logic [11:0] q_r, run_r;
  logic [15:0] cnt_r;
  logic        done_r;

  logic        core_en_s = 1'b1;
  logic [0:0]  sel_s = '0;
  logic [0:0]  q_s, run_s;
  logic [1:0]  cnt_s;
  logic        done_s;

  int errors = 0;
  int checks = 0;
  int edges = 0;
  int ma[16];
  int mr[16];
  int ms;
  int rises_s = 0;

  logic [15:0] exp_run_a, exp_cnt_a, qpre_a, runpre_a;
  logic [11:0] exp_run_r;
  logic [15:0] exp_cnt_r;
  logic        exp_run_s;
  logic [1:0]  exp_cnt_s;
  logic        exp_done_a, exp_done_r, exp_done_s;

  always #5 clk = ~clk;

  servstolic_grid dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .core_en(core_en_a), .cnt_clr(cnt_clr), .sel(sel_a),
    .q(q_a), .run(run_a), .cnt(cnt_a), .seq_done(done_a));

  servstolic_grid #(.NROW(3), .NCOL(4)) dut_r (
    .wb_clk(clk), .wb_rst_n(rst_n), .core_en(core_en_a[11:0]), .cnt_clr(cnt_clr), .sel(sel_r),
    .q(q_r), .run(run_r), .cnt(cnt_r), .seq_done(done_r));

  servstolic_grid #(.NROW(1), .NCOL(1), .STAGGER(S_S), .CNT_W(2)) dut_s (
    .wb_clk(clk), .wb_rst_n(rst_n), .core_en(core_en_s), .cnt_clr(cnt_clr), .sel(sel_s),
    .q(q_s), .run(run_s), .cnt(cnt_s), .seq_done(done_s));

  task automatic zero_models();
    for (int k = 0; k < 16; k++) begin ma[k] = 0; mr[k] = 0; end
    ms = 0;
    edges = 0;
  endtask

  // One clock edge: predict post-edge outputs from pre-edge state, then update counter models
  task automatic tick();
    logic [15:0] qa0, ra0;
    logic [11:0] qr0, rr0;
    logic qs0, rs0, clr0, rs_n;
    qa0 = q_a; ra0 = run_a; qr0 = q_r; rr0 = run_r; qs0 = q_s[0]; rs0 = run_s[0];
    clr0 = cnt_clr; rs_n = rst_n;
    for (int k = 0; k < N_A; k++) exp_run_a[k] = rs_n && (edges >= (k + 1) * S_A) && core_en_a[k];
    for (int k = 0; k < N_R; k++) exp_run_r[k] = rs_n && (edges >= (k + 1) * S_R) && core_en_a[k];
    exp_run_s  = rs_n && (edges >= S_S) && core_en_s;
    exp_done_a = rs_n && (edges >= N_A * S_A);
    exp_done_r = rs_n && (edges >= N_R * S_R);
    exp_done_s = rs_n && (edges >= N_S * S_S);
    exp_cnt_a  = rs_n ? 16'(ma[sel_a]) : 16'd0;
    exp_cnt_r  = (rs_n && sel_r < N_R) ? 16'(mr[sel_r]) : 16'd0;
    exp_cnt_s  = (rs_n && sel_s == 1'b0) ? 2'(ms) : 2'd0;
    qpre_a = qa0; runpre_a = ra0;
    @(posedge clk); #1;
    if (rs_n) edges++;
    for (int k = 0; k < N_A; k++) begin
      if (!rs_n || clr0) ma[k] = 0;
      else if (ra0[k] && !qa0[k] && q_a[k] && ma[k] < 65535) ma[k]++;
    end
    for (int k = 0; k < N_R; k++) begin
      if (!rs_n || clr0) mr[k] = 0;
      else if (rr0[k] && !qr0[k] && q_r[k] && mr[k] < 65535) mr[k]++;
    end
    if (rs0 && !qs0 && q_s[0]) rises_s++;
    if (!rs_n || clr0) ms = 0;
    else if (rs0 && !qs0 && q_s[0] && ms < 3) ms++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    zero_models();
    tick();
    tick();
    rst_n = 1'b1;
    edges = 0;
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    checks++; if (q_a !== 16'd0 || run_a !== 16'd0) begin errors++; $display("FAIL reset_a q/run: got %h/%h required 0/0", q_a, run_a); end
    checks++; if (cnt_a !== 16'd0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_a cnt/done: got %h/%b required 0/0", cnt_a, done_a); end
    checks++; if (run_r !== 12'd0 || cnt_r !== 16'd0 || done_r !== 1'b0) begin errors++; $display("FAIL reset_r: got run %h cnt %h done %b", run_r, cnt_r, done_r); end
    checks++; if (run_s !== 1'b0 || cnt_s !== 2'd0 || done_s !== 1'b0 || q_s !== 1'b0) begin errors++; $display("FAIL reset_s: got run %b cnt %h done %b q %b", run_s, cnt_s, done_s, q_s); end
  endtask

  task automatic test_release_order();
    int fr[16];
    int fdone;
    for (int k = 0; k < 16; k++) fr[k] = 0;
    fdone = 0;
    core_en_a = '1; sel_a = 4'd3; sel_r = 4'd0; sel_s = 1'b0;
    apply_reset();
    for (int t = 0; t < 140; t++) begin
      tick();
      checks++; if (run_a !== exp_run_a) begin errors++; $display("FAIL release run_a edge %0d: got %h required %h", edges, run_a, exp_run_a); end
      checks++; if (done_a !== exp_done_a) begin errors++; $display("FAIL release done_a edge %0d: got %b required %b", edges, done_a, exp_done_a); end
      checks++; if (cnt_a !== exp_cnt_a) begin errors++; $display("FAIL release cnt_a edge %0d: got %0d required %0d", edges, cnt_a, exp_cnt_a); end
      checks++; if (run_r !== exp_run_r || done_r !== exp_done_r) begin errors++; $display("FAIL release dut_r edge %0d: got %h/%b required %h/%b", edges, run_r, done_r, exp_run_r, exp_done_r); end
      checks++; if (run_s !== exp_run_s || done_s !== exp_done_s) begin errors++; $display("FAIL release dut_s edge %0d: got %b/%b required %b/%b", edges, run_s, done_s, exp_run_s, exp_done_s); end
      checks++; if ((q_a & ~runpre_a) !== (qpre_a & ~runpre_a)) begin errors++; $display("FAIL q_hold edge %0d: got %h required %h", edges, q_a & ~runpre_a, qpre_a & ~runpre_a); end
      for (int k = 0; k < 16; k++) if (run_a[k] && fr[k] == 0) fr[k] = edges;
      if (done_a && fdone == 0) fdone = edges;
    end
    for (int k = 0; k < 16; k++) begin
      checks++; if (fr[k] != 8 * k + 9) begin errors++; $display("FAIL run_first_rise[%0d]: got edge %0d required edge %0d", k, fr[k], 8 * k + 9); end
    end
    checks++; if (fdone != 129) begin errors++; $display("FAIL seq_done_first_rise: got edge %0d required edge 129", fdone); end
  endtask

  task automatic test_async_reset();
    int fr0;
    apply_reset();
    for (int t = 0; t < 40; t++) tick();
    checks++; if (run_a !== exp_run_a || run_a === 16'd0) begin errors++; $display("FAIL pre_async run_a: got %h required %h", run_a, exp_run_a); end
    rst_n = 1'b0;
    zero_models();
    #1;
    checks++; if (run_a !== 16'd0 || q_a !== 16'd0) begin errors++; $display("FAIL async_reset run/q: got %h/%h required 0/0", run_a, q_a); end
    checks++; if (cnt_a !== 16'd0 || done_a !== 1'b0 || cnt_r !== 16'd0 || done_s !== 1'b0) begin errors++; $display("FAIL async_reset cnt/done: got %h/%b", cnt_a, done_a); end
    tick();
    rst_n = 1'b1;
    edges = 0;
    fr0 = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++; if (run_a !== exp_run_a) begin errors++; $display("FAIL post_async run_a edge %0d: got %h required %h", edges, run_a, exp_run_a); end
      if (run_a[0] && fr0 == 0) fr0 = edges;
    end
    checks++; if (fr0 != 9) begin errors++; $display("FAIL post_async run0_rise: got edge %0d required edge 9", fr0); end
  endtask

  task automatic test_disabled_core();
    logic [15:0] held;
    core_en_a = '1; core_en_a[5] = 1'b0; sel_a = 4'd5;
    apply_reset();
    while (edges < 200) begin
      tick();
      checks++; if (run_a !== exp_run_a || done_a !== exp_done_a) begin errors++; $display("FAIL disabled run/done edge %0d: got %h/%b required %h/%b", edges, run_a, done_a, exp_run_a, exp_done_a); end
      checks++; if (cnt_a !== exp_cnt_a) begin errors++; $display("FAIL disabled cnt edge %0d: got %0d required %0d", edges, cnt_a, exp_cnt_a); end
    end
    checks++; if (run_a[5] !== 1'b0 || done_a !== 1'b1 || cnt_a !== 16'd0) begin errors++; $display("FAIL disabled_core5 at 200: run %b done %b cnt %0d required 0 1 0", run_a[5], done_a, cnt_a); end
    core_en_a[5] = 1'b1;
    tick();
    checks++; if (run_a[5] !== 1'b1) begin errors++; $display("FAIL reenable_core5 edge %0d: got %b required 1", edges, run_a[5]); end
    sel_a = 4'd7;
    tick();
    held = cnt_a;
    core_en_a[7] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++; if (run_a !== exp_run_a || cnt_a !== exp_cnt_a) begin errors++; $display("FAIL disable_core7 edge %0d: run %h cnt %0d required %h %0d", edges, run_a, cnt_a, exp_run_a, exp_cnt_a); end
      checks++; if ((q_a & ~runpre_a) !== (qpre_a & ~runpre_a)) begin errors++; $display("FAIL q_hold core7 edge %0d: got %h required %h", edges, q_a, qpre_a); end
    end
    checks++; if (cnt_a === 16'd0 && held !== 16'd0) begin errors++; $display("FAIL core7 count retained: got %0d required nonzero", cnt_a); end
    core_en_a[7] = 1'b1;
    tick();
    checks++; if (run_a[7] !== 1'b1) begin errors++; $display("FAIL reenable_core7: got %b required 1", run_a[7]); end
  endtask

  task automatic test_counting();
    core_en_a = '1; sel_a = 4'd3;
    for (int t = 0; t < 300; t++) begin
      cnt_clr = ($urandom_range(0, 5) == 0);
      if (t % 8 == 0) begin sel_a = 4'($urandom_range(0, 15)); sel_r = 4'($urandom_range(0, 15)); end
      tick();
      checks++; if (cnt_a !== exp_cnt_a) begin errors++; $display("FAIL count cnt_a sel %0d edge %0d: got %0d required %0d", sel_a, edges, cnt_a, exp_cnt_a); end
      checks++; if (cnt_r !== exp_cnt_r) begin errors++; $display("FAIL count cnt_r sel %0d edge %0d: got %0d required %0d", sel_r, edges, cnt_r, exp_cnt_r); end
      checks++; if (cnt_s !== exp_cnt_s) begin errors++; $display("FAIL count cnt_s edge %0d: got %0d required %0d", edges, cnt_s, exp_cnt_s); end
    end
    cnt_clr = 1'b0; sel_a = 4'd3;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++; if (cnt_a !== exp_cnt_a) begin errors++; $display("FAIL count q3 edge %0d: got %0d required %0d", edges, cnt_a, exp_cnt_a); end
    end
    checks++; if (cnt_a === 16'd0) begin errors++; $display("FAIL count q3 progress: got 0 required nonzero"); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tick();
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL cnt_clr two edges later: got %0d required 0", cnt_a); end
  endtask

  task automatic test_saturation();
    sel_s = 1'b0; core_en_s = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    rises_s = 0;
    for (int t = 0; t < 120; t++) begin
      tick();
      checks++; if (cnt_s !== exp_cnt_s) begin errors++; $display("FAIL sat cnt_s edge %0d: got %0d required %0d", edges, cnt_s, exp_cnt_s); end
    end
    checks++; if (rises_s < 5 || cnt_s !== 2'd3) begin errors++; $display("FAIL saturation: got cnt %0d after %0d rises required 3", cnt_s, rises_s); end
    for (int t = 0; t < 20; t++) tick();
    checks++; if (cnt_s !== 2'd3) begin errors++; $display("FAIL saturation hold: got %0d required 3", cnt_s); end
  endtask

  task automatic test_out_of_range();
    sel_r = 4'd13; sel_s = 1'b1;
    tick(); tick();
    checks++; if (cnt_r !== 16'd0) begin errors++; $display("FAIL sel_out_of_range r: got %0d required 0", cnt_r); end
    checks++; if (cnt_s !== 2'd0) begin errors++; $display("FAIL sel_out_of_range s: got %0d required 0", cnt_s); end
    sel_r = 4'd11;
    tick(); tick();
    checks++; if (cnt_r !== exp_cnt_r) begin errors++; $display("FAIL sel_in_range r: got %0d required %0d", cnt_r, exp_cnt_r); end
  endtask

  initial begin
    zero_models();
    test_reset();
    test_release_order();
    test_async_reset();
    test_disabled_core();
    test_counting();
    test_saturation();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/servstolic_grid.md
Name: servstolic_grid

Overview:
- Parametrised NROW x NCOL array of servant cores with a per-core control and observation layer.
- Staggered reset release: cores come out of reset one at a time, STAGGER cycles apart, to limit simultaneous start-up activity.
- Per-core run enable.
- Per-core rising-edge counters on each core's q output, read back through a select port.
- Top-level array for multi-core FPGA/ASIC bring-up and simulation.

Parameters:
- NROW, 4, rows of cores.
- NCOL, 4, columns of cores; N = NROW*NCOL; core index i = NCOL*row + col.
- MEMFILE, "blinky.hex", program image passed to every servant.
- MEMSIZE, 16384, servant memory bytes.
- SIM, 1, passed to servant.
- WITH_CSR, 1, passed to servant.
- ALIGN, 0, passed to servant.
- STAGGER, 8, cycles between consecutive core releases; must be >= 1.
- CNT_W, 16, edge counter width.

Ports:
- wb_clk  in  1  single clock for all logic and all servants.
- wb_rst_n  in  1  asynchronous, active-low reset.
- core_en  in  N  per-core enable; 0 holds that core in reset.
- cnt_clr  in  1  synchronous clear of all edge counters.
- sel  in  SEL_W  counter readout select; SEL_W = max(1, clog2(N)).
- q  out  N  registered copy of each servant q.
- run  out  N  1 = core i is out of reset.
- cnt  out  CNT_W  edge count of core sel.
- seq_done  out  1  all cores have been released by the sequencer.

Behaviour:
- Reset (wb_rst_n=0, asynchronous):
  - q=0, run=0, cnt=0, seq_done=0.
  - Counters=0, release mask=0, sequencer in WAIT with timer=0 and idx=0.
  - All servants held in reset.
- Servant reset: each servant's active-high wb_rst = core_rst_r[i].
  - core_rst_r[i] <= ~(rel_mask[i] & core_en[i]), registered, reset value 1.
  - run = ~core_rst_r.
- Sequencer FSM (WAIT, DONE):
  - WAIT: timer increments each cycle. When timer==STAGGER-1: set rel_mask[idx], timer<=0.
    - If idx==N-1, go to DONE; else idx<=idx+1.
  - DONE: terminal until reset. rel_mask stays all ones.
  - seq_done <= (state==DONE), registered.
- Timing: edge 1 is the first rising wb_clk with wb_rst_n high.
  - rel_mask[k] sets at edge (k+1)*STAGGER.
  - run[k] rises at edge (k+1)*STAGGER+1, if core_en[k]=1.
  - seq_done rises at edge N*STAGGER+1, coincident with run[N-1].
- core_en independence:
  - The sequencer advances regardless of core_en.
  - core_en[i]=0 drops run[i] one edge later, in any state.
  - Re-asserting core_en[i] after release restores run[i] one edge later; no re-stagger.
- q path: q[i] <= servant_q[i], one-cycle latency. q is held at its last value while the core is in reset.
- Edge counters:
  - Increment cnt_mem[i] when servant_q[i] & ~q[i] & run[i].
  - Saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 clears all counters; clear wins over a same-cycle increment.
  - Counters are not cleared by core_en; values are retained while a core is disabled.
- Readout:
  - cnt <= cnt_mem[sel] when sel<N, else cnt <= 0.
  - Latency one cycle after sel or counter change.
- Reset mid-sequence: reasserting wb_rst_n=0 immediately returns everything to reset values. The sequence restarts from core 0 on release.
- N=1: SEL_W=1; the single core is released at edge STAGGER; seq_done follows the same rule.

Test Plan:
- Release order: N=16, STAGGER=8, core_en=all ones, release reset.
  - run[k] rises at edge 8k+9: run[0] at 9, run[15] at 129.
  - seq_done rises at edge 129. run bits rise strictly in index order.
- Disabled core: core_en[5]=0 throughout.
  - run[5] stays 0; seq_done still rises at 129; cnt for sel=5 reads 0.
  - Set core_en[5]=1 at edge 200 -> run[5]=1 at edge 201.
- Counting: with blinky running, sel=3.
  - cnt increments exactly once per rising q[3] and matches a bench count of q[3] edges.
  - Pulse cnt_clr -> cnt=0 two edges later.
  - cnt_clr coincident with an edge -> counter=0.
- Saturation: CNT_W=2, force 5 rising edges on core 0 -> cnt reads 3 and stays 3.
- Async reset mid-sequence: assert wb_rst_n=0 at edge 40.
  - run, q, cnt, seq_done go to 0 before the next edge.
  - After release, run[0] rises 9 edges later.
- Out-of-range select: N=12 (NROW=3, NCOL=4), sel=13 -> cnt=0.
